// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU control path.
// Holds the sequencer FSM states, ALU mode codes and local opcodes.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WB,
        ST_RESP
    } state_t;

    localparam logic [2:0] MODE_ADD = 3'b000;
    localparam logic [2:0] MODE_ADC = 3'b001;
    localparam logic [2:0] MODE_SUB = 3'b010;
    localparam logic [2:0] MODE_INC = 3'b011;
    localparam logic [2:0] MODE_DEC = 3'b100;
    localparam logic [2:0] MODE_AND = 3'b101;
    localparam logic [2:0] MODE_OR  = 3'b110;
    localparam logic [2:0] MODE_XOR = 3'b111;

    localparam logic [3:0] OP_LDA = 4'b1000;
    localparam logic [3:0] OP_CLA = 4'b1001;

endpackage

// File: rtl/alu_op_sequencer.sv
// Command sequencer driving the 8-bit ALU: IDLE -> EXEC -> WB -> RESP.
// Optional ALU_OP_SEQUENCER_OPCNT_EN adds a 16-bit response counter op_count.
module alu_op_sequencer #(
    parameter int DW  = 8,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [OPW-1:0] cmd_op,
    input  logic [DW-1:0]  cmd_data,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    output logic [2:0]     alu_mode,
    output logic           alu_ee,
    output logic           alu_eo,
    input  logic [DW-1:0]  alu_bus,
    input  logic           alu_carry,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [DW-1:0]  rsp_data,
    output logic           rsp_zero,
    output logic           rsp_carry
`ifdef ALU_OP_SEQUENCER_OPCNT_EN
    ,
    output logic [15:0]    op_count
`endif
);

    import alu_pkg::*;

    state_t state;

    logic is_alu;
    logic is_lda;
    logic is_cla;

    assign is_alu = ~cmd_op[3];
    assign is_lda = (cmd_op == OP_LDA);
    assign is_cla = (cmd_op == OP_CLA);

    // Ready only while idle and out of reset.
    assign cmd_ready = rst_n && (state == ST_IDLE);

    // Main FSM with registered ALU controls and response bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_mode  <= '0;
            alu_ee    <= 1'b0;
            alu_eo    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_carry <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        unique case (1'b1)
                            is_alu: begin
                                alu_b    <= cmd_data;
                                alu_mode <= cmd_op[2:0];
                                alu_ee   <= 1'b1;
                                state    <= ST_EXEC;
                            end
                            is_lda: begin
                                alu_a     <= cmd_data;
                                rsp_data  <= cmd_data;
                                rsp_zero  <= (cmd_data == '0);
                                rsp_valid <= 1'b1;
                                state     <= ST_RESP;
                            end
                            is_cla: begin
                                alu_a     <= '0;
                                rsp_data  <= '0;
                                rsp_zero  <= 1'b1;
                                rsp_carry <= 1'b0;
                                rsp_valid <= 1'b1;
                                state     <= ST_RESP;
                            end
                            default: begin
                                rsp_data  <= alu_a;
                                rsp_zero  <= (alu_a == '0);
                                rsp_valid <= 1'b1;
                                state     <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    alu_ee <= 1'b0;
                    alu_eo <= 1'b1;
                    state  <= ST_WB;
                end
                ST_WB: begin
                    alu_eo    <= 1'b0;
                    alu_a     <= alu_bus;
                    rsp_data  <= alu_bus;
                    rsp_zero  <= (alu_bus == '0);
                    rsp_carry <= alu_carry;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_OP_SEQUENCER_OPCNT_EN
    // Count completed response handshakes, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (rsp_valid && rsp_ready) begin
            op_count <= op_count + 16'd1;
        end
    end
`endif

endmodule
